// File: rtl/mcif_rd_req_gen.sv
// mcif read-command front end: splits a linear beat command into credit-limited bursts.
// Optional macro MCIF_RD_REQ_4K_SPLIT_EN additionally stops bursts at 4KB boundaries.
module mcif_rd_req_gen #(
   parameter int DATA_W    = 256,
   parameter int LEN_W     = 4,
   parameter int CNT_W     = 24,
   parameter int OST_BEATS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   input  logic [31:0]          cmd_addr,
   input  logic [CNT_W-1:0]     cmd_beats,
   output logic                 done,
   output logic                 rd_req_vld,
   input  logic                 rd_req_rdy,
   output logic [LEN_W+31:0]    rd_req_pd,
   input  logic                 rd_resp_vld,
   output logic                 rd_resp_rdy,
   input  logic [DATA_W-1:0]    rd_resp_pd,
   output logic                 rd_fifo_pop,
   output logic                 dout_vld,
   input  logic                 dout_rdy,
   output logic [DATA_W-1:0]    dout_pd
);

   localparam int BYTES     = DATA_W / 8;
   localparam int BSH       = $clog2(BYTES);
   localparam int MAX_BURST = 1 << LEN_W;
   localparam int BL_W      = LEN_W + 1;
   localparam int CR_W      = $clog2(OST_BEATS + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_WAIT} state_t;

   state_t              r_state;
   logic [31:0]         r_addr;
   logic [CNT_W-1:0]    r_rem;
   logic [CNT_W-1:0]    r_total;
   logic [CNT_W-1:0]    r_rcv_cnt;
   logic [CR_W-1:0]     r_credit;
   logic [BL_W-1:0]     r_blen;
   logic                r_cmd_rdy;
   logic                r_rd_req_vld;
   logic [LEN_W+31:0]   r_rd_req_pd;
   logic                r_done;

   logic                w_pop;
   logic [CNT_W-1:0]    w_rcv_nxt;
   logic [BL_W-1:0]     w_blen;
   logic                w_take;

   // Response path is a zero-latency pass-through; each accepted beat returns one credit.
   assign w_pop       = rd_resp_vld & dout_rdy;
   assign rd_resp_rdy = dout_rdy;
   assign rd_fifo_pop = w_pop;
   assign dout_vld    = rd_resp_vld;
   assign dout_pd     = rd_resp_pd;
   assign w_rcv_nxt   = r_rcv_cnt + CNT_W'(w_pop);

`ifdef MCIF_RD_REQ_4K_SPLIT_EN
   logic [12:0] w_pg_bytes;
   logic [12:0] w_pg_beats;
   assign w_pg_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
   assign w_pg_beats = w_pg_bytes >> BSH;
`endif

   always_comb begin
      w_blen = BL_W'(MAX_BURST);
      if (r_rem < CNT_W'(MAX_BURST))
         w_blen = r_rem[BL_W-1:0];
`ifdef MCIF_RD_REQ_4K_SPLIT_EN
      if (13'(w_blen) > w_pg_beats)
         w_blen = w_pg_beats[BL_W-1:0];
`endif
   end

   assign w_take = (r_state == S_CALC) && (r_credit >= CR_W'(w_blen));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_rem        <= '0;
         r_total      <= '0;
         r_rcv_cnt    <= '0;
         r_credit     <= CR_W'(OST_BEATS);
         r_blen       <= '0;
         r_cmd_rdy    <= 1'b0;
         r_rd_req_vld <= 1'b0;
         r_rd_req_pd  <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_rcv_cnt <= w_rcv_nxt;
         // NOTE: a returned beat and a burst reservation in the same cycle must both land.
         r_credit  <= r_credit + CR_W'(w_pop) - (w_take ? CR_W'(w_blen) : CR_W'(0));
         case (r_state)
            S_IDLE: begin
               r_cmd_rdy <= 1'b1;
               if (cmd_vld && r_cmd_rdy) begin
                  r_addr    <= cmd_addr & ~32'(BYTES - 1);
                  r_rem     <= cmd_beats;
                  r_total   <= cmd_beats;
                  r_rcv_cnt <= '0;
                  if (cmd_beats == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_cmd_rdy <= 1'b0;
                     r_state   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_blen      <= w_blen;
               r_rd_req_pd <= {LEN_W'(w_blen - BL_W'(1)), r_addr};
               if (w_take) begin
                  r_rd_req_vld <= 1'b1;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (rd_req_rdy) begin
                  r_rd_req_vld <= 1'b0;
                  r_addr       <= r_addr + (32'(r_blen) << BSH);
                  r_rem        <= r_rem - CNT_W'(r_blen);
                  r_state      <= (r_rem != CNT_W'(r_blen)) ? S_CALC : S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_rcv_nxt == r_total) begin
                  r_done    <= 1'b1;
                  r_cmd_rdy <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_rdy    = r_cmd_rdy;
   assign rd_req_vld = r_rd_req_vld;
   assign rd_req_pd  = r_rd_req_pd;
   assign done       = r_done;

   // A beat can only come back while some of the credit pool is reserved.
   a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst)
      w_pop |-> (r_credit < CR_W'(OST_BEATS)));

endmodule
